spi_slave_regif: RTL and testbench

//  FPGA-side SPI slave (mode 0, CPOL=0/CPHA=0) that terminates the host SPI link and drives the internal register bus.

---
 rtl/fpga_regs_pkg.sv | 22 ++
 rtl/spi_slave_regif_if.sv | 31 +++
 rtl/spi_sync_edge.sv | 40 ++++
 rtl/spi_slave_regif.sv | 154 +++++++++++++++
 tb/tb_spi_slave_regif.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpga_regs_pkg.sv
// Shared register-bus constants, register map and the SPI bridge state encoding.
package fpga_regs_pkg;

   localparam int FPGA_REG_AWIDTH = 8;
   localparam int FPGA_REG_DWIDTH = 16;

   // Position of the write flag inside the address field of a frame.
   localparam int WR_FLAG_BIT = FPGA_REG_AWIDTH - 1;

   localparam logic [FPGA_REG_AWIDTH-2:0] REG_ID       = 7'h01;
   localparam logic [FPGA_REG_AWIDTH-2:0] REG_SCRATCH0 = 7'h10;
   localparam logic [FPGA_REG_AWIDTH-2:0] REG_STATUS   = 7'h21;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ADDR   = 3'd1,
      RDWAIT = 3'd2,
      DATA   = 3'd3,
      DONE   = 3'd4
   } fsm_t;

endpackage

// File: rtl/spi_slave_regif_if.sv
// Internal register bus driven by the SPI bridge (master) and served by the register file (slave).
interface spi_slave_regif_if #(
   parameter int AWIDTH = fpga_regs_pkg::FPGA_REG_AWIDTH,
   parameter int DWIDTH = fpga_regs_pkg::FPGA_REG_DWIDTH
);

   // reg_wr/reg_rd are single-cycle strobes qualifying reg_adr (and reg_wdata for writes);
   // there is no back-pressure: reg_rdata must be valid RD_LATENCY cycles after reg_rd.
   logic [AWIDTH-2:0] reg_adr;
   logic [DWIDTH-1:0] reg_wdata;
   logic              reg_wr;
   logic              reg_rd;
   logic [DWIDTH-1:0] reg_rdata;

   modport master (
      output reg_adr,
      output reg_wdata,
      output reg_wr,
      output reg_rd,
      input  reg_rdata
   );

   modport slave (
      input  reg_adr,
      input  reg_wdata,
      input  reg_wr,
      input  reg_rd,
      output reg_rdata
   );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for SPI pins; the edge input also gets 1-cycle rise/fall strobes.
module spi_sync_edge #(
   parameter int STAGES = 2,
   parameter int WIDTH  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_edge_async,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_sync,
   output logic             o_rise,
   output logic             o_fall
);

   // Bit 0 of each stage carries the edge-detected signal, the upper bits the level-only ones.
   logic [WIDTH:0] r_sync [STAGES];
   logic           r_edge_prev;
   logic           w_edge_now;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            r_sync[i] <= '0;
         end
         r_edge_prev <= 1'b0;
      end else begin
         r_sync[0] <= {i_async, i_edge_async};
         for (int i = 1; i < STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
         r_edge_prev <= w_edge_now;
      end
   end

   assign w_edge_now = r_sync[STAGES-1][0];
   assign o_sync     = r_sync[STAGES-1][WIDTH:1];
   assign o_rise     = w_edge_now & ~r_edge_prev;
   assign o_fall     = ~w_edge_now & r_edge_prev;

endmodule

// File: rtl/spi_slave_regif.sv
// SPI mode-0 slave bridging host frames {addr, data} (MSB first) onto the register bus.
// The address MSB selects write (1) or read (0); read data is returned in the data phase.
module spi_slave_regif
   import fpga_regs_pkg::*;
#(
   parameter int AWIDTH      = FPGA_REG_AWIDTH,
   parameter int DWIDTH      = FPGA_REG_DWIDTH,
   parameter int RD_LATENCY  = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_spi_cs,
   input  logic              i_spi_clk,
   input  logic              i_spi_mosi,
   output logic              o_spi_miso,
   output fsm_t              o_state,
   spi_slave_regif_if.master reg_bus
);

   localparam int CW  = $clog2(AWIDTH + DWIDTH);
   localparam int RXW = ((AWIDTH > DWIDTH) ? AWIDTH : DWIDTH) - 1;
   localparam int WW  = $clog2(RD_LATENCY + 1);

   localparam logic [CW-1:0] ADDR_LAST = CW'(AWIDTH - 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(AWIDTH + DWIDTH - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(RD_LATENCY);

   logic [1:0] w_sync;
   logic       w_cs;
   logic       w_mosi;
   logic       w_rise;
   logic       w_fall;

   fsm_t              r_state;
   logic [CW-1:0]     r_cnt;
   logic [WW-1:0]     r_wait;
   logic [RXW-1:0]    r_rx;
   logic [DWIDTH-1:0] r_tx;
   logic [AWIDTH-2:0] r_adr;
   logic [DWIDTH-1:0] r_wdata;
   logic              r_reg_wr;
   logic              r_reg_rd;
   logic              r_miso;
   logic              r_is_read;
   logic              r_cs_prev;

   spi_sync_edge #(
      .STAGES (SYNC_STAGES),
      .WIDTH  (2)
   ) u_sync (
      .clk          (clk),
      .rst          (rst),
      .i_edge_async (i_spi_clk),
      .i_async      ({i_spi_mosi, i_spi_cs}),
      .o_sync       (w_sync),
      .o_rise       (w_rise),
      .o_fall       (w_fall)
   );

   assign w_cs   = w_sync[0];
   assign w_mosi = w_sync[1];

   // A frame starts only on a seen high-to-low cs transition, so a frame cut by reset
   // stays ignored until the host deasserts cs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_wait    <= '0;
         r_rx      <= '0;
         r_tx      <= '0;
         r_adr     <= '0;
         r_wdata   <= '0;
         r_reg_wr  <= 1'b0;
         r_reg_rd  <= 1'b0;
         r_miso    <= 1'b0;
         r_is_read <= 1'b0;
         r_cs_prev <= 1'b0;
      end else begin
         r_reg_wr  <= 1'b0;
         r_reg_rd  <= 1'b0;
         r_cs_prev <= w_cs;
         if (w_cs) begin
            r_state <= IDLE;
            r_miso  <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (r_cs_prev) begin
                     r_state   <= ADDR;
                     r_cnt     <= '0;
                     r_rx      <= '0;
                     r_tx      <= '0;
                     r_is_read <= 1'b0;
                  end
               end
               ADDR: begin
                  if (w_rise) begin
                     r_cnt <= r_cnt + CW'(1);
                     r_rx  <= {r_rx[RXW-2:0], w_mosi};
                     if (r_cnt == ADDR_LAST) begin
                        r_adr     <= {r_rx[AWIDTH-3:0], w_mosi};
                        r_is_read <= ~r_rx[AWIDTH-2];
                        if (r_rx[AWIDTH-2]) begin
                           r_state <= DATA;
                        end else begin
                           r_reg_rd <= 1'b1;
                           r_wait   <= '0;
                           r_state  <= RDWAIT;
                        end
                     end
                  end
               end
               RDWAIT: begin
                  if (r_wait == WAIT_LAST) begin
                     r_tx    <= reg_bus.reg_rdata;
                     r_state <= DATA;
                  end else begin
                     r_wait <= r_wait + WW'(1);
                  end
               end
               DATA: begin
                  if (w_rise) begin
                     r_cnt <= r_cnt + CW'(1);
                     r_rx  <= {r_rx[RXW-2:0], w_mosi};
                     if (r_cnt == DATA_LAST) begin
                        r_state <= DONE;
                        if (!r_is_read) begin
                           r_wdata  <= {r_rx[DWIDTH-2:0], w_mosi};
                           r_reg_wr <= 1'b1;
                        end
                     end
                  end else if (w_fall && r_is_read) begin
                     r_miso <= r_tx[DWIDTH-1];
                     r_tx   <= {r_tx[DWIDTH-2:0], 1'b0};
                  end
               end
               DONE: begin
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign o_spi_miso        = r_miso;
   assign o_state           = r_state;
   assign reg_bus.reg_adr   = r_adr;
   assign reg_bus.reg_wdata = r_wdata;
   assign reg_bus.reg_wr    = r_reg_wr;
   assign reg_bus.reg_rd    = r_reg_rd;

endmodule

// File: tb/tb_spi_slave_regif.sv
// Bench for spi_slave_regif: host-side SPI driver, small register file, strobe scoreboard.
`timescale 1ns/1ps
module tb_spi_slave_regif;
   import fpga_regs_pkg::*;

   localparam int AW   = 8;
   localparam int DW   = 16;
   localparam int HALF = 10;

   logic clk      = 1'b0;
   logic rst      = 1'b1;
   logic spi_cs   = 1'b1;
   logic spi_clk  = 1'b0;
   logic spi_mosi = 1'b0;
   logic spi_miso;
   fsm_t state;

   int n_checks = 0;
   int n_fail   = 0;
   int both_cnt = 0;
   int miso_hi  = 0;

   logic [AW+DW-1:0] exp_q[$];
   logic [AW+DW-1:0] obs_q[$];
   logic [DW-1:0]    mem [128];

   spi_slave_regif_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

   spi_slave_regif #(
      .AWIDTH      (AW),
      .DWIDTH      (DW),
      .RD_LATENCY  (1),
      .SYNC_STAGES (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_spi_cs   (spi_cs),
      .i_spi_clk  (spi_clk),
      .i_spi_mosi (spi_mosi),
      .o_spi_miso (spi_miso),
      .o_state    (state),
      .reg_bus    (bus)
   );

   always #5 clk = ~clk;

   // Register file with one cycle of read latency.
   always @(posedge clk) begin
      if (rst) begin
         bus.reg_rdata <= '0;
         for (int i = 0; i < 128; i++) mem[i] <= 16'hC000 | 16'(i);
         mem[REG_ID] <= 16'h1234;
      end else begin
         if (bus.reg_rd) bus.reg_rdata <= mem[bus.reg_adr];
         if (bus.reg_wr) mem[bus.reg_adr] <= bus.reg_wdata;
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (bus.reg_rd || bus.reg_wr)
            obs_q.push_back({bus.reg_wr, bus.reg_adr, bus.reg_wr ? bus.reg_wdata : 16'h0000});
         if (bus.reg_rd && bus.reg_wr) both_cnt++;
         if (spi_miso) miso_hi++;
      end
   endtask

   task automatic send_bit(input logic b, output logic s);
      spi_mosi = b;
      tick(HALF);
      spi_clk = 1'b1;
      s = spi_miso;
      tick(HALF);
      spi_clk = 1'b0;
   endtask

   task automatic xfer(input logic [AW-1:0] a, input logic [DW-1:0] d, input int nbits,
                       input int extra, output logic [DW-1:0] rdw, output logic [3:0] ext);
      logic [AW+DW-1:0] fr;
      logic s;
      fr  = {a, d};
      rdw = '0;
      ext = '0;
      spi_cs = 1'b0;
      tick(HALF);
      for (int i = 0; i < AW + DW; i++) begin
         if (i < nbits) begin
            send_bit(fr[AW+DW-1-i], s);
            if (i >= AW) rdw = {rdw[DW-2:0], s};
         end
      end
      for (int i = 0; i < extra; i++) begin
         send_bit(1'b1, s);
         ext = {ext[2:0], s};
      end
      tick(HALF);
      spi_cs   = 1'b1;
      spi_mosi = 1'b0;
      tick(3 * HALF);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(4);
      n_checks++; if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b want 0", spi_miso); end
      n_checks++; if (bus.reg_wr !== 1'b0) begin n_fail++; $display("FAIL reset_wr: got %b want 0", bus.reg_wr); end
      n_checks++; if (bus.reg_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %b want 0", bus.reg_rd); end
      n_checks++; if (bus.reg_adr !== 7'h00) begin n_fail++; $display("FAIL reset_adr: got %h want 00", bus.reg_adr); end
      n_checks++; if (bus.reg_wdata !== 16'h0000) begin n_fail++; $display("FAIL reset_wdata: got %h want 0000", bus.reg_wdata); end
      n_checks++; if (state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", state, IDLE); end
      rst = 1'b0;
      tick(4);
   endtask

   task automatic test_read();
      logic [DW-1:0] rdw;
      logic [3:0] ext;
      logic [AW+DW-1:0] e, o;
      exp_q.push_back({1'b0, REG_ID, 16'h0000});
      xfer({1'b0, REG_ID}, 16'h0000, AW + DW, 0, rdw, ext);
      n_checks++; if (rdw !== 16'h1234) begin n_fail++; $display("FAIL read_data: got %h want 1234", rdw); end
      n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL read_strobes: got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '1;
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL read_bus: got %h want %h", o, e); end
      end
      obs_q.delete();
   endtask

   task automatic test_write();
      logic [DW-1:0] rdw;
      logic [3:0] ext;
      logic [AW-1:0] a;
      logic [AW+DW-1:0] e, o;
      a = {1'b0, REG_SCRATCH0};
      a[WR_FLAG_BIT] = 1'b1;
      miso_hi = 0;
      exp_q.push_back({1'b1, REG_SCRATCH0, 16'h00AA});
      xfer(a, 16'h00AA, AW + DW, 0, rdw, ext);
      n_checks++; if (miso_hi != 0) begin n_fail++; $display("FAIL write_miso: got %0d high cycles want 0", miso_hi); end
      n_checks++; if (bus.reg_wdata !== 16'h00AA) begin n_fail++; $display("FAIL write_wdata: got %h want 00AA", bus.reg_wdata); end
      n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL write_strobes: got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '1;
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL write_bus: got %h want %h", o, e); end
      end
      obs_q.delete();
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] rdw;
      logic [3:0] ext;
      logic [DW-1:0] vals [4];
      logic [DW-1:0] got [4];
      logic [AW+DW-1:0] e, o;
      vals[0] = 16'h00AA; vals[1] = 16'h00BB; vals[2] = 16'h00CC; vals[3] = 16'h00DD;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({1'b1, REG_SCRATCH0 + 7'(i), vals[i]});
         xfer({1'b1, REG_SCRATCH0 + 7'(i)}, vals[i], AW + DW, 0, rdw, ext);
      end
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({1'b0, REG_SCRATCH0 + 7'(i), 16'h0000});
         xfer({1'b0, REG_SCRATCH0 + 7'(i)}, 16'h0000, AW + DW, 0, got[i], ext);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (got[i] !== vals[i]) begin n_fail++; $display("FAIL b2b_read%0d: got %h want %h", i, got[i], vals[i]); end
      end
      n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_strobes: got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '1;
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL b2b_bus: got %h want %h", o, e); end
      end
      obs_q.delete();
   endtask

   task automatic test_abort();
      logic [DW-1:0] rdw, rd_id, rd_s1;
      logic [3:0] ext;
      logic [AW+DW-1:0] e, o;
      xfer({1'b1, REG_SCRATCH0 + 7'd1}, 16'h5555, 12, 0, rdw, ext);
      exp_q.push_back({1'b0, REG_ID, 16'h0000});
      xfer({1'b0, REG_ID}, 16'h0000, AW + DW, 0, rd_id, ext);
      exp_q.push_back({1'b0, REG_SCRATCH0 + 7'd1, 16'h0000});
      xfer({1'b0, REG_SCRATCH0 + 7'd1}, 16'h0000, AW + DW, 0, rd_s1, ext);
      n_checks++; if (rd_id !== 16'h1234) begin n_fail++; $display("FAIL abort_read_id: got %h want 1234", rd_id); end
      n_checks++; if (rd_s1 !== 16'h00BB) begin n_fail++; $display("FAIL abort_reg_kept: got %h want 00BB", rd_s1); end
      n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL abort_strobes: got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '1;
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL abort_bus: got %h want %h", o, e); end
      end
      obs_q.delete();
   endtask

   task automatic test_reset_midframe();
      logic [AW+DW-1:0] fr;
      logic [DW-1:0] rdw;
      logic [3:0] ext;
      logic [AW+DW-1:0] e, o;
      logic s;
      fr = {1'b1, REG_SCRATCH0 + 7'd2, 16'h7E7E};
      spi_cs = 1'b0;
      tick(HALF);
      for (int i = 0; i < 10; i++) send_bit(fr[AW+DW-1-i], s);
      rst = 1'b1;
      tick(2);
      n_checks++; if (bus.reg_adr !== 7'h00) begin n_fail++; $display("FAIL rstmid_adr: got %h want 00", bus.reg_adr); end
      n_checks++; if (bus.reg_wdata !== 16'h0000) begin n_fail++; $display("FAIL rstmid_wdata: got %h want 0000", bus.reg_wdata); end
      n_checks++; if (state !== IDLE) begin n_fail++; $display("FAIL rstmid_state: got %0d want %0d", state, IDLE); end
      rst = 1'b0;
      for (int i = 10; i < AW + DW; i++) send_bit(fr[AW+DW-1-i], s);
      tick(HALF);
      n_checks++; if (state !== IDLE) begin n_fail++; $display("FAIL rstmid_ignored: got %0d want %0d", state, IDLE); end
      spi_cs = 1'b1;
      spi_mosi = 1'b0;
      tick(3 * HALF);
      exp_q.push_back({1'b0, REG_ID, 16'h0000});
      xfer({1'b0, REG_ID}, 16'h0000, AW + DW, 0, rdw, ext);
      n_checks++; if (rdw !== 16'h1234) begin n_fail++; $display("FAIL rstmid_read: got %h want 1234", rdw); end
      n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rstmid_strobes: got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '1;
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL rstmid_bus: got %h want %h", o, e); end
      end
      obs_q.delete();
   endtask

   task automatic test_extra_clocks();
      logic [DW-1:0] rdw;
      logic [3:0] ext;
      logic [AW+DW-1:0] e, o;
      exp_q.push_back({1'b0, REG_STATUS, 16'h0000});
      xfer({1'b0, REG_STATUS}, 16'h0000, AW + DW, 4, rdw, ext);
      n_checks++; if (rdw !== 16'hC021) begin n_fail++; $display("FAIL extra_read: got %h want C021", rdw); end
      n_checks++; if (ext !== 4'hF) begin n_fail++; $display("FAIL extra_miso: got %b want 1111", ext); end
      n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL extra_strobes: got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '1;
         n_checks++; if (o !== e) begin n_fail++; $display("FAIL extra_bus: got %h want %h", o, e); end
      end
      obs_q.delete();
      n_checks++; if (both_cnt != 0) begin n_fail++; $display("FAIL both_strobes: got %0d cycles want 0", both_cnt); end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_back_to_back();
      test_abort();
      test_reset_midframe();
      test_extra_clocks();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
